// File: rtl/m6809_pkg.sv
// Shared types for the 6809 bus arbiter: tenure FSM states and burst defaults.
// Purely declarative; no logic, no latency, no flow control.
package m6809_pkg;

    typedef enum logic [1:0] {
        ST_CPU       = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_DMA       = 2'd2,
        ST_RELEASE   = 2'd3
    } arb_state_t;

    localparam int DEFAULT_MAX_BURST = 16;

endpackage

// File: rtl/m6809_bus_arbiter.sv
// Purpose: shares one ROM/RAM bus between a 6809 core and a DMA requester via HALT/BA.
// Latency: dma_ack combinational in DMA; read data and rom_wr_err one cycle after ack.
// Backpressure: requester holds dma_req/addr/data stable until dma_ack; bursts capped at MAX_BURST.
module m6809_bus_arbiter
    import m6809_pkg::*;
#(
    parameter int MAX_BURST    = DEFAULT_MAX_BURST,
    parameter int ROM_BASE_BIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw_n,
    output logic [7:0]  cpu_din,
    output logic        cpu_halt,
    input  logic        cpu_ba,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_rw_n,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rw_n,
    output logic        sel_rom,
    output logic        sel_ram,
    input  logic [7:0]  rom_dout,
    input  logic [7:0]  ram_dout,
    output logic        rom_wr_err
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [7:0] BURST_LAST  = 8'(MAX_BURST - 1);

    arb_state_t state;
    arb_state_t state_nxt;

    logic [7:0] burst_cnt;
    logic       cpu_held;
    logic       bus_en;
    logic       core_owns;
    logic       dma_rom_q;
    logic       cpu_rom_q;
    logic [7:0] rom_q;
    logic       dma_wr_rom;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CPU;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_halt  = 1'b0;
        dma_ack   = 1'b0;
        bus_en    = 1'b0;
        core_owns = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_dout;
        mem_rw_n  = cpu_rw_n;

        case (state)
            ST_CPU: begin
                bus_en    = 1'b1;
                core_owns = 1'b1;
                if (dma_req && cpu_held) begin
                    state_nxt = ST_HALT_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                cpu_halt  = 1'b1;
                core_owns = 1'b1;
                // Once BA is up the core has floated its bus; stop decoding its stale address.
                bus_en    = !cpu_ba;
                if (cpu_ba) begin
                    state_nxt = ST_DMA;
                end
            end
            ST_DMA: begin
                cpu_halt  = 1'b1;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                dma_ack   = dma_req && (burst_cnt < BURST_LIMIT);
                bus_en    = dma_ack;
                // ROM writes are acked but never reach the bus; idle DMA cycles read nothing.
                mem_rw_n  = dma_rw_n || dma_addr[ROM_BASE_BIT] || !dma_ack;
                if (!dma_req || !dma_ack || (burst_cnt == BURST_LAST)) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                mem_rw_n = 1'b1;
                if (!cpu_ba) begin
                    state_nxt = ST_CPU;
                end
            end
            default: begin
                state_nxt = ST_CPU;
            end
        endcase

        sel_rom = bus_en && mem_addr[ROM_BASE_BIT];
        sel_ram = bus_en && !mem_addr[ROM_BASE_BIT];
    end

    assign dma_wr_rom = dma_ack && !dma_rw_n && dma_addr[ROM_BASE_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt  <= 8'h00;
            cpu_held   <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_rom_q  <= 1'b0;
            cpu_rom_q  <= 1'b0;
            rom_q      <= 8'h00;
            rom_wr_err <= 1'b0;
        end else begin
            cpu_held   <= (state == ST_CPU);
            dma_rvalid <= dma_ack && dma_rw_n;
            dma_rom_q  <= dma_addr[ROM_BASE_BIT];
            rom_q      <= rom_dout;
            rom_wr_err <= dma_wr_rom;
            if (core_owns) begin
                cpu_rom_q <= mem_addr[ROM_BASE_BIT];
            end
            if (state_nxt == ST_CPU) begin
                burst_cnt <= 8'h00;
            end else if (dma_ack && (burst_cnt != 8'hFF)) begin
                burst_cnt <= burst_cnt + 8'h01;
            end
        end
    end

    // ROM data is registered so both memories present read data with the same one-cycle lag.
    assign cpu_din   = cpu_rom_q ? rom_q : ram_dout;
    assign dma_rdata = dma_rvalid ? (dma_rom_q ? rom_q : ram_dout) : 8'h00;

endmodule

// File: tb/tb_m6809_bus_arbiter.sv
// Directed bench for m6809_bus_arbiter: CPU decode, HALT/BA handshake, bursts, ROM write drop, reset abort.
module tb_m6809_bus_arbiter;
    import m6809_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw_n;
    logic [7:0]  cpu_din;
    logic        cpu_halt;
    logic        cpu_ba;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_rw_n;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rw_n;
    logic        sel_rom;
    logic        sel_ram;
    logic [7:0]  rom_dout;
    logic [7:0]  ram_dout;
    logic        rom_wr_err;

    int n_cmp = 0;
    int n_bad = 0;

    m6809_bus_arbiter #(.MAX_BURST(4), .ROM_BASE_BIT(15)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rw_n(cpu_rw_n),
        .cpu_din(cpu_din), .cpu_halt(cpu_halt), .cpu_ba(cpu_ba),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rw_n(dma_rw_n), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rw_n(mem_rw_n), .sel_rom(sel_rom), .sel_ram(sel_ram),
        .rom_dout(rom_dout), .ram_dout(ram_dout), .rom_wr_err(rom_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core model: BA follows HALT one cycle later; walks the arbiter into DMA.
    task automatic enter_dma();
        int n = 0;
        dma_req = 1'b1;
        while (dut.state != ST_DMA && n < 20) begin
            cpu_ba = cpu_halt;
            tick();
            n++;
        end
        n_cmp++;
        if (dut.state !== ST_DMA) begin
            n_bad++;
            $display("FAIL enter_dma: state=%0d required=%0d", dut.state, ST_DMA);
        end
    endtask

    task automatic return_to_cpu();
        int n = 0;
        dma_req = 1'b0;
        while (dut.state != ST_CPU && n < 20) begin
            cpu_ba = cpu_halt;
            tick();
            n++;
        end
        cpu_ba = 1'b0;
        n_cmp++;
        if (dut.state !== ST_CPU) begin
            n_bad++;
            $display("FAIL return_to_cpu: state=%0d required=%0d", dut.state, ST_CPU);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (cpu_halt !== 1'b0)   begin n_bad++; $display("FAIL rst_halt: got %b want 0", cpu_halt); end
        n_cmp++; if (dma_ack !== 1'b0)    begin n_bad++; $display("FAIL rst_ack: got %b want 0", dma_ack); end
        n_cmp++; if (dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", dma_rvalid); end
        n_cmp++; if (rom_wr_err !== 1'b0) begin n_bad++; $display("FAIL rst_romerr: got %b want 0", rom_wr_err); end
        n_cmp++; if (dma_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", dma_rdata); end
        n_cmp++; if (dut.state !== ST_CPU) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", dut.state, ST_CPU); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_addr = 16'h8000;
        cpu_rw_n = 1'b1;
        rom_dout = 8'hA5;
        tick();
        n_cmp++; if (sel_rom !== 1'b1)  begin n_bad++; $display("FAIL cpu_rom_sel: got %b want 1", sel_rom); end
        n_cmp++; if (sel_ram !== 1'b0)  begin n_bad++; $display("FAIL cpu_rom_selram: got %b want 0", sel_ram); end
        n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL cpu_rom_halt: got %b want 0", cpu_halt); end
        n_cmp++; if (cpu_din !== 8'hA5) begin n_bad++; $display("FAIL cpu_rom_din: got %h want a5", cpu_din); end
        n_cmp++; if (mem_addr !== 16'h8000) begin n_bad++; $display("FAIL cpu_mem_addr: got %h want 8000", mem_addr); end
        cpu_addr = 16'h0010;
        ram_dout = 8'h3C;
        tick();
        n_cmp++; if (sel_ram !== 1'b1)  begin n_bad++; $display("FAIL cpu_ram_sel: got %b want 1", sel_ram); end
        n_cmp++; if (cpu_din !== 8'h3C) begin n_bad++; $display("FAIL cpu_ram_din: got %h want 3c", cpu_din); end
    endtask

    task automatic test_halt_handshake();
        dma_addr  = 16'h0010;
        dma_rw_n  = 1'b1;
        dma_wdata = 8'h00;
        dma_req   = 1'b1;
        #1;
        n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL hs_halt_pre: got %b want 0", cpu_halt); end
        tick();
        n_cmp++; if (cpu_halt !== 1'b1) begin n_bad++; $display("FAIL hs_halt_1cyc: got %b want 1", cpu_halt); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL hs_ack_early: got %b want 0", dma_ack); end
        end
        cpu_ba = 1'b1;
        #1;
        n_cmp++; if ((sel_rom | sel_ram) !== 1'b0) begin n_bad++; $display("FAIL hs_idle_sel: got %b want 0", sel_rom | sel_ram); end
        n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL hs_ack_ba: got %b want 0", dma_ack); end
        tick();
        n_cmp++; if (dma_ack !== 1'b1) begin n_bad++; $display("FAIL hs_first_ack: got %b want 1", dma_ack); end
        n_cmp++; if (mem_addr !== 16'h0010) begin n_bad++; $display("FAIL hs_dma_addr: got %h want 0010", mem_addr); end
        n_cmp++; if (sel_ram !== 1'b1) begin n_bad++; $display("FAIL hs_dma_selram: got %b want 1", sel_ram); end
        tick();
        n_cmp++; if (dma_rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %b want 1", dma_rvalid); end
        n_cmp++; if (dma_rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_rdata: got %h want 3c", dma_rdata); end
        dma_req = 1'b0;
        #1;
        n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack_drop: got %b want 0", dma_ack); end
        tick();
        n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL rel_halt: got %b want 0", cpu_halt); end
        n_cmp++; if (mem_rw_n !== 1'b1) begin n_bad++; $display("FAIL rel_rw: got %b want 1", mem_rw_n); end
        n_cmp++; if ((sel_rom | sel_ram) !== 1'b0) begin n_bad++; $display("FAIL rel_sel: got %b want 0", sel_rom | sel_ram); end
        cpu_ba = 1'b0;
        tick();
        n_cmp++; if (dut.state !== ST_CPU) begin n_bad++; $display("FAIL rel_to_cpu: got %0d want %0d", dut.state, ST_CPU); end
        n_cmp++; if (dut.burst_cnt !== 8'h00) begin n_bad++; $display("FAIL rel_cnt: got %h want 00", dut.burst_cnt); end
    endtask

    task automatic test_max_burst();
        int acks = 0;
        int cpu_cycles = 0;
        int phase = 0;
        int guard = 0;
        bit saw_dma = 0;
        dma_addr = 16'h0020;
        dma_rw_n = 1'b1;
        dma_req  = 1'b1;
        while (phase < 2 && guard < 60) begin
            if (dma_ack) acks++;
            if (phase == 0 && dut.state == ST_RELEASE) begin
                phase = 1;
                n_cmp++; if (acks !== 4) begin n_bad++; $display("FAIL burst_acks: got %0d want 4", acks); end
            end else if (phase == 1 && dut.state == ST_CPU) begin
                cpu_cycles++;
            end else if (phase == 1 && dut.state == ST_HALT_WAIT) begin
                phase = 2;
            end
            if (phase < 2) begin
                cpu_ba = cpu_halt;
                tick();
                guard++;
            end
        end
        n_cmp++; if (phase !== 2) begin n_bad++; $display("FAIL burst_rearm: phase %0d want 2", phase); end
        n_cmp++; if (cpu_cycles < 1) begin n_bad++; $display("FAIL burst_cpu_gap: got %0d want >=1", cpu_cycles); end
        // Requester gives up while HALT is pending: tenure must still run, with no acks.
        dma_req = 1'b0;
        acks  = 0;
        guard = 0;
        while (dut.state != ST_CPU && guard < 20) begin
            if (dma_ack) acks++;
            if (dut.state == ST_DMA) saw_dma = 1;
            cpu_ba = cpu_halt;
            tick();
            guard++;
        end
        cpu_ba = 1'b0;
        n_cmp++; if (saw_dma !== 1'b1) begin n_bad++; $display("FAIL drop_via_dma: got %b want 1", saw_dma); end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL drop_acks: got %0d want 0", acks); end
        n_cmp++; if (dut.state !== ST_CPU) begin n_bad++; $display("FAIL drop_to_cpu: got %0d want %0d", dut.state, ST_CPU); end
        tick();
    endtask

    task automatic test_rom_write();
        dma_addr  = 16'hC000;
        dma_wdata = 8'h55;
        dma_rw_n  = 1'b0;
        enter_dma();
        #1;
        n_cmp++; if (dma_ack !== 1'b1)    begin n_bad++; $display("FAIL romwr_ack: got %b want 1", dma_ack); end
        n_cmp++; if (mem_rw_n !== 1'b1)   begin n_bad++; $display("FAIL romwr_rw: got %b want 1", mem_rw_n); end
        n_cmp++; if (sel_rom !== 1'b1)    begin n_bad++; $display("FAIL romwr_sel: got %b want 1", sel_rom); end
        n_cmp++; if (rom_wr_err !== 1'b0) begin n_bad++; $display("FAIL romwr_err_early: got %b want 0", rom_wr_err); end
        tick();
        dma_req = 1'b0;
        n_cmp++; if (rom_wr_err !== 1'b1) begin n_bad++; $display("FAIL romwr_err_pulse: got %b want 1", rom_wr_err); end
        n_cmp++; if (dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL romwr_rvalid: got %b want 0", dma_rvalid); end
        tick();
        n_cmp++; if (rom_wr_err !== 1'b0) begin n_bad++; $display("FAIL romwr_err_once: got %b want 0", rom_wr_err); end
        return_to_cpu();
    endtask

    task automatic test_dma_rom_read();
        dma_addr = 16'h8004;
        dma_rw_n = 1'b1;
        rom_dout = 8'h5A;
        enter_dma();
        #1;
        n_cmp++; if (sel_rom !== 1'b1) begin n_bad++; $display("FAIL romrd_sel: got %b want 1", sel_rom); end
        tick();
        dma_req = 1'b0;
        rom_dout = 8'hFF;
        #1;
        n_cmp++; if (dma_rvalid !== 1'b1) begin n_bad++; $display("FAIL romrd_rvalid: got %b want 1", dma_rvalid); end
        n_cmp++; if (dma_rdata !== 8'h5A) begin n_bad++; $display("FAIL romrd_rdata: got %h want 5a", dma_rdata); end
        return_to_cpu();
    endtask

    task automatic test_reset_mid_burst();
        dma_addr = 16'h0030;
        dma_rw_n = 1'b1;
        enter_dma();
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (cpu_halt !== 1'b0)   begin n_bad++; $display("FAIL abort_halt: got %b want 0", cpu_halt); end
        n_cmp++; if (dma_ack !== 1'b0)    begin n_bad++; $display("FAIL abort_ack: got %b want 0", dma_ack); end
        n_cmp++; if (dut.state !== ST_CPU) begin n_bad++; $display("FAIL abort_state: got %0d want %0d", dut.state, ST_CPU); end
        n_cmp++; if (dut.burst_cnt !== 8'h00) begin n_bad++; $display("FAIL abort_cnt: got %h want 00", dut.burst_cnt); end
        n_cmp++; if (dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL abort_rvalid: got %b want 0", dma_rvalid); end
        reset   = 1'b0;
        dma_req = 1'b0;
        cpu_ba  = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_dout  = 8'h00;
        cpu_rw_n  = 1'b1;
        cpu_ba    = 1'b0;
        dma_req   = 1'b0;
        dma_addr  = 16'h0000;
        dma_wdata = 8'h00;
        dma_rw_n  = 1'b1;
        rom_dout  = 8'hA5;
        ram_dout  = 8'h3C;

        test_reset();
        test_cpu_read();
        test_halt_handshake();
        test_max_burst();
        test_rom_write();
        test_dma_rom_read();
        test_reset_mid_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m6809_bus_arbiter.md
M6809_BUS_ARBITER -- requirements
Module: m6809_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning the maximum number of DMA transfers per bus tenure (range 1..255).
REQ-002 SHALL have parameter ROM_BASE_BIT, default 15, meaning the address bit that selects ROM when 1 and RAM when 0.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  core address.
- cpu_dout  in  8  core write data.
- cpu_rw_n  in  1  core direction (1 = read).
- cpu_din  out  8  read data to core.
- cpu_halt  out  1  halt request to core.
- cpu_ba  in  1  core bus-available acknowledge.
- dma_req  in  1  DMA requester wants one transfer.
- dma_addr  in  16  DMA address.
- dma_wdata  in  8  DMA write data.
- dma_rw_n  in  1  DMA direction (1 = read).
- dma_ack  out  1  transfer accepted this cycle.
- dma_rdata  out  8  DMA read data.
- dma_rvalid  out  1  dma_rdata valid.
- mem_addr  out  16  shared memory address.
- mem_wdata  out  8  shared write data.
- mem_rw_n  out  1  shared direction.
- sel_rom  out  1  ROM select.
- sel_ram  out  1  RAM select.
- rom_dout  in  8  ROM read data (combinational).
- ram_dout  in  8  RAM read data (valid one cycle after address).
- rom_wr_err  out  1  single-cycle pulse: DMA write to ROM dropped.

Function
REQ-004 SHALL implement the FSM states CPU, HALT_WAIT, DMA and RELEASE.
REQ-005 In CPU, SHALL drive cpu_halt=0 and route cpu_addr/cpu_dout/cpu_rw_n to mem_*; CPU→HALT_WAIT when dma_req=1, provided CPU has been held ≥1 cycle.
REQ-006 In HALT_WAIT, SHALL drive cpu_halt=1 with the core still owning mem_*; HALT_WAIT→DMA on the first cycle cpu_ba=1.
REQ-007 In DMA, SHALL drive cpu_halt=1 and route dma_* to mem_*, asserting dma_ack combinationally in every cycle with dma_req=1.
REQ-008 In DMA, SHALL go to RELEASE when dma_req=0 or when the ack count reaches MAX_BURST.
REQ-009 In RELEASE, SHALL drive cpu_halt=0 with mem_rw_n=1 and no select active; RELEASE→CPU when cpu_ba=0.
REQ-010 SHALL hold the 8-bit burst counter at zero in CPU, increment it per dma_ack, and never wrap.
REQ-011 SHALL decode sel_rom = mem_addr[ROM_BASE_BIT] and sel_ram = !mem_addr[ROM_BASE_BIT] in CPU and DMA, with both selects at 0 in HALT_WAIT-bus-idle and RELEASE.
REQ-012 On a DMA write with sel_rom=1, SHALL force mem_rw_n=1, still ack, and pulse rom_wr_err the next cycle.
REQ-013 For a DMA read acked in cycle N, SHALL drive dma_rvalid=1 with registered data in cycle N+1, taking RAM data from ram_dout and ROM data from rom_dout registered in cycle N.
REQ-014 cpu_din SHALL mux rom_dout/ram_dout by the registered CPU-phase select, mirroring the RAM one-cycle latency.
REQ-015 A requester holding dma_req SHALL keep dma_addr, dma_wdata and dma_rw_n stable until it sees dma_ack; the arbiter does not register DMA inputs.
REQ-016 If dma_req falls in HALT_WAIT, SHALL proceed to DMA anyway, then immediately to RELEASE, with zero acks.

Reset
REQ-017 While reset=1, SHALL enter CPU with cpu_halt=0, dma_ack=0, dma_rvalid=0, rom_wr_err=0, burst counter 0 and dma_rdata=8'h00, and SHALL abort any tenure at any point.

Structure
REQ-018 SHALL keep the FSM state enum and the default MAX_BURST in shared package m6809_pkg.
REQ-019 SHALL be a single module with no sub-modules; address decode is inline.

Verification
REQ-020 With no dma_req, CPU read 16'h8000 (rom_dout=8'hA5) -> cpu_halt stays 0, sel_rom=1, cpu_din=8'hA5.
REQ-021 With dma_req and cpu_ba rising after 3 cycles -> cpu_halt=1 after 1 cycle, first dma_ack exactly 1 cycle after cpu_ba=1.
REQ-022 DMA read of 16'h0010 with ram_dout=8'h3C -> dma_rvalid=1 and dma_rdata=8'h3C one cycle after dma_ack.
REQ-023 With dma_req held continuously and MAX_BURST=4 -> exactly 4 acks, RELEASE, ≥1 CPU cycle, then a new HALT_WAIT.
REQ-024 DMA write to 16'hC000 -> mem_rw_n=1, dma_ack=1, rom_wr_err pulses once.
REQ-025 reset asserted in DMA mid-burst -> next cycle cpu_halt=0, dma_ack=0, state CPU, counter 0.
